// File: rtl/controlador_busca_param_if.sv
// Handshake/status bundle between the search controller and its host and evaluators.
// The controller binds the slave modport; the host side binds master.
interface controlador_busca_param_if #(
    parameter int ITER_WIDTH = 16
);
    logic                  iniciar_in;
    logic                  abortar_in;
    logic                  tem_ativo_in;
    logic                  aa_pronto_in;
    logic                  lvv_pronto_in;
    logic                  caminho_pronto_in;
    logic                  lido_in;

    logic                  aguardando_out;
    logic                  iniciar_out;
    logic                  atualizar_classificacao_out;
    logic                  atualizar_buffer_out;
    logic                  expandir_out;
    logic                  construir_caminho_out;
    logic                  caminho_pronto_out;
    logic                  erro_out;
    logic [ITER_WIDTH-1:0] iter_count_out;
    logic [2:0]            estado_out;

    // Level handshakes: every *_pronto_in / lido_in is sampled on the rising clk edge
    // and acted on only in the state that waits for it; no ready back-pressure exists.
    modport master (
        output iniciar_in, abortar_in, tem_ativo_in, aa_pronto_in,
               lvv_pronto_in, caminho_pronto_in, lido_in,
        input  aguardando_out, iniciar_out, atualizar_classificacao_out,
               atualizar_buffer_out, expandir_out, construir_caminho_out,
               caminho_pronto_out, erro_out, iter_count_out, estado_out
    );

    modport slave (
        input  iniciar_in, abortar_in, tem_ativo_in, aa_pronto_in,
               lvv_pronto_in, caminho_pronto_in, lido_in,
        output aguardando_out, iniciar_out, atualizar_classificacao_out,
               atualizar_buffer_out, expandir_out, construir_caminho_out,
               caminho_pronto_out, erro_out, iter_count_out, estado_out
    );
endinterface

// File: rtl/controlador_busca_param.sv
// Search sequencer: init, evaluate active nodes, expand, build path, report.
// Define CONTROLADOR_BUSCA_WATCHDOG_EN to stop in ERRO after MAX_ITER expansions.
module controlador_busca_param #(
    parameter int ITER_WIDTH = 16,
    parameter int MAX_ITER   = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    controlador_busca_param_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE               = 3'd0,
        S_INICIALIZAR        = 3'd1,
        S_TEM_ATIVO          = 3'd2,
        S_ERRO               = 3'd3,
        S_ATUALIZAR_BUFFER   = 3'd4,
        S_EXPANDIR_ATUALIZAR = 3'd5,
        S_CONSTRUIR_CAMINHO  = 3'd6,
        S_PRONTO             = 3'd7
    } state_t;

    localparam logic [ITER_WIDTH-1:0] ITER_SAT = '1;
    localparam logic [ITER_WIDTH-1:0] ITER_ONE = ITER_WIDTH'(1);
`ifdef CONTROLADOR_BUSCA_WATCHDOG_EN
    localparam logic [ITER_WIDTH-1:0] ITER_LIMIT = ITER_WIDTH'(MAX_ITER);
`endif

    if (ITER_WIDTH < 4 || ITER_WIDTH > 32) begin : g_bad_iter_width
        $error("ITER_WIDTH out of range 4..32");
    end
    if (MAX_ITER < 1 || longint'(MAX_ITER) > ((longint'(1) << ITER_WIDTH) - 1)) begin : g_bad_max_iter
        $error("MAX_ITER out of range 1..2^ITER_WIDTH-1");
    end

    state_t                state_q, state_d;
    logic [ITER_WIDTH-1:0] iter_count_q, iter_count_d;
    logic                  expandir_q, expandir_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            iter_count_q <= '0;
            expandir_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_count_q <= iter_count_d;
            expandir_q   <= expandir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        iter_count_d = iter_count_q;
        // The expand strobe is the state decode pushed one cycle later.
        expandir_d   = (state_q == S_EXPANDIR_ATUALIZAR);
        if (bus.abortar_in) begin
            state_d = S_IDLE;
        end else if (bus.iniciar_in) begin
            state_d      = S_INICIALIZAR;
            iter_count_d = '0;
        end else begin
            case (state_q)
                S_INICIALIZAR: begin
                    if (bus.tem_ativo_in && bus.aa_pronto_in) state_d = S_TEM_ATIVO;
                end
                S_TEM_ATIVO: begin
                    if (bus.aa_pronto_in) begin
                        if (bus.tem_ativo_in) begin
`ifdef CONTROLADOR_BUSCA_WATCHDOG_EN
                            if (iter_count_q == ITER_LIMIT) begin
                                state_d = S_ERRO;
                            end else
`endif
                            begin
                                state_d = S_ATUALIZAR_BUFFER;
                                if (iter_count_q != ITER_SAT) iter_count_d = iter_count_q + ITER_ONE;
                            end
                        end else begin
                            state_d = S_CONSTRUIR_CAMINHO;
                        end
                    end
                end
                S_ATUALIZAR_BUFFER: begin
                    if (bus.aa_pronto_in) state_d = S_EXPANDIR_ATUALIZAR;
                end
                // A coincident aa_pronto_in is ignored here; TEM_ATIVO samples it afresh.
                S_EXPANDIR_ATUALIZAR: begin
                    if (bus.lvv_pronto_in) state_d = S_TEM_ATIVO;
                end
                S_CONSTRUIR_CAMINHO: begin
                    if (bus.caminho_pronto_in) state_d = S_PRONTO;
                end
                S_PRONTO, S_ERRO: begin
                    if (bus.lido_in) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.aguardando_out              = (state_q == S_IDLE);
        bus.iniciar_out                 = (state_q == S_INICIALIZAR);
        bus.atualizar_classificacao_out = (state_q == S_TEM_ATIVO) ||
                                          (bus.iniciar_in && !bus.abortar_in);
        bus.atualizar_buffer_out        = (state_q == S_ATUALIZAR_BUFFER) && bus.aa_pronto_in;
        bus.expandir_out                = expandir_q;
        bus.construir_caminho_out       = (state_q == S_CONSTRUIR_CAMINHO);
        bus.caminho_pronto_out          = (state_q == S_PRONTO);
`ifdef CONTROLADOR_BUSCA_WATCHDOG_EN
        bus.erro_out                    = (state_q == S_ERRO);
`else
        bus.erro_out                    = 1'b0;
`endif
        bus.iter_count_out              = iter_count_q;
        bus.estado_out                  = state_q;
    end

endmodule

// File: tb/tb_controlador_busca_param.sv
// Directed bench for controlador_busca_param: per-cycle compare against a reference model
// plus hand-computed literal checks for the search, watchdog, abort, reset and strobe cases.
module tb_controlador_busca_param;

    localparam int IW     = 4;
    localparam int MI     = 2;
    localparam int IT_MAX = (1 << IW) - 1;
`ifdef CONTROLADOR_BUSCA_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int S_IDLE = 0, S_INIC = 1, S_TEM = 2, S_ERRO = 3;
    localparam int S_BUF = 4, S_EXP = 5, S_CONS = 6, S_PRONTO = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    controlador_busca_param_if #(.ITER_WIDTH(IW)) bus();

    controlador_busca_param #(.ITER_WIDTH(IW), .MAX_ITER(MI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_state = S_IDLE;
    int   m_iter = 0;
    int   m_nxt;
    logic m_exp = 1'b0;
    logic log_en = 1'b0;
    int   st_log[$];

    // Reference model: transition table and counter rules stated directly.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = S_IDLE;
            m_iter  = 0;
            m_exp   = 1'b0;
        end else begin
            m_exp = (m_state == S_EXP);
            m_nxt = m_state;
            if (bus.abortar_in) m_nxt = S_IDLE;
            else if (bus.iniciar_in) begin
                m_nxt  = S_INIC;
                m_iter = 0;
            end else begin
                case (m_state)
                    S_INIC:   if (bus.tem_ativo_in && bus.aa_pronto_in) m_nxt = S_TEM;
                    S_TEM:    if (bus.aa_pronto_in) begin
                                  if (!bus.tem_ativo_in) m_nxt = S_CONS;
                                  else if (WD && m_iter == MI) m_nxt = S_ERRO;
                                  else begin
                                      m_nxt  = S_BUF;
                                      m_iter = (m_iter < IT_MAX) ? m_iter + 1 : IT_MAX;
                                  end
                              end
                    S_BUF:    if (bus.aa_pronto_in) m_nxt = S_EXP;
                    S_EXP:    if (bus.lvv_pronto_in) m_nxt = S_TEM;
                    S_CONS:   if (bus.caminho_pronto_in) m_nxt = S_PRONTO;
                    S_PRONTO: if (bus.lido_in) m_nxt = S_IDLE;
                    S_ERRO:   if (bus.lido_in) m_nxt = S_IDLE;
                    default:  m_nxt = m_state;
                endcase
            end
            m_state = m_nxt;
        end
    end

    logic [14:0] exp_w, got_w;

    always @(negedge clk) begin
        exp_w = {m_state == S_IDLE, m_state == S_INIC,
                 (m_state == S_TEM) || (bus.iniciar_in && !bus.abortar_in),
                 (m_state == S_BUF) && bus.aa_pronto_in, m_exp,
                 m_state == S_CONS, m_state == S_PRONTO, m_state == S_ERRO,
                 m_iter[3:0], m_state[2:0]};
        got_w = {bus.aguardando_out, bus.iniciar_out, bus.atualizar_classificacao_out,
                 bus.atualizar_buffer_out, bus.expandir_out, bus.construir_caminho_out,
                 bus.caminho_pronto_out, bus.erro_out, bus.iter_count_out, bus.estado_out};
        n_vec++;
        if (got_w !== exp_w) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t: got %b expected %b (ag,ini,cls,buf,exp,cons,pronto,erro,iter,estado)",
                     $time, got_w, exp_w);
        end
        if (log_en) st_log.push_back(int'(bus.estado_out));
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic drive(input logic ini, input logic abo, input logic tem, input logic aa,
                         input logic lvv, input logic cam, input logic lido);
        @(posedge clk);
        #1;
        bus.iniciar_in        = ini;
        bus.abortar_in        = abo;
        bus.tem_ativo_in      = tem;
        bus.aa_pronto_in      = aa;
        bus.lvv_pronto_in     = lvv;
        bus.caminho_pronto_in = cam;
        bus.lido_in           = lido;
    endtask

    int exp_seq[13] = '{1, 2, 4, 5, 2, 4, 5, 2, 4, 5, 2, 6, 7};

    initial begin
        bus.iniciar_in = 1'b0; bus.abortar_in = 1'b0; bus.tem_ativo_in = 1'b0;
        bus.aa_pronto_in = 1'b0; bus.lvv_pronto_in = 1'b0;
        bus.caminho_pronto_in = 1'b0; bus.lido_in = 1'b0;

        #3;
        chk("rst_aguardando", 32'(bus.aguardando_out), 1);
        chk("rst_estado", 32'(bus.estado_out), 0);
        chk("rst_iter", 32'(bus.iter_count_out), 0);
        chk("rst_expandir", 32'(bus.expandir_out), 0);
        chk("rst_erro", 32'(bus.erro_out), 0);
        chk("rst_pronto", 32'(bus.caminho_pronto_out), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Normal search: three expansions, then no active nodes.
        drive(1, 0, 0, 0, 0, 0, 0);
        #5 log_en = 1'b1;
        repeat (10) drive(0, 0, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
`ifndef CONTROLADOR_BUSCA_WATCHDOG_EN
        #2 chk("search_pronto_held", 32'(bus.caminho_pronto_out), 1);
`endif
        drive(0, 0, 0, 0, 0, 0, 1);
        #5 log_en = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 chk("search_idle", 32'(bus.estado_out), S_IDLE);
`ifdef CONTROLADOR_BUSCA_WATCHDOG_EN
        chk("search_wd_iter", 32'(bus.iter_count_out), MI);
`else
        chk("search_iter", 32'(bus.iter_count_out), 3);
        chk("search_log_len", 32'(st_log.size() >= 13), 1);
        for (int i = 0; i < 13; i++)
            if (i < st_log.size()) chk($sformatf("search_seq[%0d]", i), 32'(st_log[i]), exp_seq[i]);
`endif

        // Continuous activity: watchdog trip or saturating counter.
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (60) drive(0, 0, 1, 1, 1, 0, 0);
        #2;
`ifdef CONTROLADOR_BUSCA_WATCHDOG_EN
        chk("wd_estado", 32'(bus.estado_out), S_ERRO);
        chk("wd_erro", 32'(bus.erro_out), 1);
        chk("wd_iter", 32'(bus.iter_count_out), MI);
`else
        chk("sat_iter", 32'(bus.iter_count_out), IT_MAX);
        chk("sat_erro", 32'(bus.erro_out), 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef CONTROLADOR_BUSCA_WATCHDOG_EN
        #2 chk("wd_lido_idle", 32'(bus.estado_out), S_IDLE);
        chk("wd_lido_iter", 32'(bus.iter_count_out), MI);
`endif
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Abort and start together while expanding.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        #2 chk("abort_in_exp", 32'(bus.estado_out), S_EXP);
        chk("abort_cls", 32'(bus.atualizar_classificacao_out), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 chk("abort_idle", 32'(bus.estado_out), S_IDLE);

        // Expand strobe lags the state by one cycle on entry and exit.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 chk("exp_n_state", 32'(bus.estado_out), S_EXP);
        chk("exp_n_strobe", 32'(bus.expandir_out), 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        #2 chk("exp_n1_strobe", 32'(bus.expandir_out), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 chk("exp_left_state", 32'(bus.estado_out), S_TEM);
        chk("exp_left_strobe", 32'(bus.expandir_out), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 chk("exp_drop", 32'(bus.expandir_out), 0);
        drive(0, 1, 0, 0, 0, 0, 0);

        // Asynchronous reset while building the path.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 chk("cons_state", 32'(bus.estado_out), S_CONS);
        chk("cons_iter", 32'(bus.iter_count_out), 1);
        rst = 1'b1;
        #1 chk("arst_estado", 32'(bus.estado_out), S_IDLE);
        chk("arst_aguardando", 32'(bus.aguardando_out), 1);
        chk("arst_construir", 32'(bus.construir_caminho_out), 0);
        chk("arst_iter", 32'(bus.iter_count_out), 0);
        chk("arst_expandir", 32'(bus.expandir_out), 0);
        #1 rst = 1'b0;
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        #2 chk("post_rst_idle", 32'(bus.estado_out), S_IDLE);
        chk("post_rst_no_pulse", 32'(bus.expandir_out), 0);

        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
